change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
// - Refund/change unit for the newspaper vending machine: the coin-issuing end of the 2-bit coin bus.
// - Takes a refund request in nickel units and pays it out one coin per cycle on coin[1:0].
//   - Encoding: 2'b01 = nickel (5c), 2'b10 = dime (10c), 2'b00 = no coin.
// - Tracks its own nickel/dime inventory, supports restocking, flags shortfall.
// PARAMETERS
// - AMT_W        4  width of refund amount, in nickel units (max 15 = 75c)
// - CNT_W        4  width of each inventory counter; saturates at 2^CNT_W-1
// - INIT_NICKELS 8  nickel inventory after reset
// - INIT_DIMES   8  dime inventory after reset
// PORTS
// - clock        in   1      single clock, rising edge
// - reset        in   1      asynchronous, active-low reset
// - req          in   1      refund request, sampled on clock edge in IDLE only
// - amount       in   AMT_W  refund in nickels, sampled with req
// - load_nickel  in   1      restock one nickel this cycle
// - load_dime    in   1      restock one dime this cycle
// - coin         out  2      coin being issued this cycle (registered)
// - busy         out  1      high in PAY and DONE
// - done         out  1      one-cycle pulse when refund finishes
// - short        out  1      valid with done: 1 = refund not fully paid
// - nickel_cnt   out  CNT_W  current nickel inventory
// - dime_cnt     out  CNT_W  current dime inventory
// BEHAVIOUR
// - Reset (reset=0, async):
//   - state=IDLE; coin=00, busy=0, done=0, short=0.
//   - nickel_cnt=INIT_NICKELS, dime_cnt=INIT_DIMES, remaining=0.
// - IDLE: req=1 at edge -> remaining<=amount, state<=PAY.
// - PAY, evaluated each edge, in priority order:
//   - remaining>=2 and dime_cnt>0    -> coin<=10, remaining-=2, dime_cnt-=1.
//   - remaining>=1 and nickel_cnt>0  -> coin<=01, remaining-=1, nickel_cnt-=1.
//   - otherwise -> coin<=00, state<=DONE, done<=1, short<=(remaining!=0).
// - DONE: next edge -> done<=0, short<=0, state<=IDLE.
// - Latency:
//   - First coin on the 2nd edge after the req edge.
//   - done rises one cycle after the last coin; amount=0 -> done on the 2nd edge, short=0.
//   - Back-to-back requests are accepted from IDLE; minimum turnaround is N coins + 3 cycles.
// - Ignored inputs: req while busy is ignored (not queued).
// - Restock:
//   - load_* increments its counter, saturating at max.
//   - Load and dispense of the same coin in one cycle: net count unchanged.
//   - Restock is allowed in any state; a coin loaded mid-PAY is usable on the next edge.
// - Counters never underflow: dispensing is gated by cnt>0.
// - Reset mid-PAY aborts immediately: no done pulse, inventory returns to INIT values.
// CONFIGURATION
// - PRECHECK_EN defined (all-or-nothing payout):
//   - On the req edge, compute d=min(dime_cnt, amount>>1).
//   - If amount-2*d > nickel_cnt: state<=DONE directly, short<=1, done<=1 on that edge.
//     - No coins issued, inventory unchanged.
//   - Otherwise proceed to PAY as above; short is always 0.
//   - The check uses the pre-edge counts and ignores same-cycle load_*.
// - PRECHECK_EN undefined: partial payout; pays what it can, then done with short=1.
// TESTING
// - Reset with defaults -> coin=00, busy=0, done=0, short=0, nickel_cnt=8, dime_cnt=8.
// - req, amount=3 -> coin 10 then 01, done=1/short=0 the following cycle; dime_cnt=7, nickel_cnt=7.
// - INIT_DIMES=0, amount=4 -> coin 01 x4 consecutive cycles, done/short=0, nickel_cnt=4.
// - INIT_NICKELS=0, INIT_DIMES=1, amount=3:
//   - PRECHECK_EN off -> coin 10, then done with short=1, dime_cnt=0.
//   - PRECHECK_EN on -> no coin, done/short=1 one edge after req, counts unchanged.
// - req pulsed during PAY -> ignored; load_dime on a dime-issue cycle -> dime_cnt unchanged;
//   15 loads from 8 -> saturates at 15.
// - Drop reset mid-PAY (amount=6) -> coin=00, busy=0 immediately, counts=8/8, no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: pays a nickel-unit refund one coin per cycle, dimes first.
// Optional `PRECHECK_EN: refuse up front any refund the inventory cannot fully cover.
module change_dispenser #(
    parameter int AMT_W        = 4,
    parameter int CNT_W        = 4,
    parameter int INIT_NICKELS = 8,
    parameter int INIT_DIMES   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             load_nickel,
    input  logic             load_dime,
    output logic [1:0]       coin,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int SW = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

    state_t           r_state;
    logic [AMT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_nickels;
    logic [CNT_W-1:0] r_dimes;
    logic [1:0]       r_coin;
    logic             r_done;
    logic             r_short;

    logic             w_give_dime;
    logic             w_give_nickel;
    logic             w_reject;
    logic [CNT_W-1:0] w_nickel_next;
    logic [CNT_W-1:0] w_dime_next;

    assign w_give_dime   = (r_state == S_PAY) &&
                           (r_remaining >= AMT_W'(2)) &&
                           (r_dimes != '0);
    assign w_give_nickel = (r_state == S_PAY) && !w_give_dime &&
                           (r_remaining != '0) &&
                           (r_nickels != '0);

`ifdef PRECHECK_EN
    logic [SW-1:0] w_half;
    logic [SW-1:0] w_dimes_use;
    logic [SW-1:0] w_need;

    // Nickels needed after the greedy dime phase, from pre-edge inventory
    assign w_half      = SW'(amount >> 1);
    assign w_dimes_use = (SW'(r_dimes) < w_half) ? SW'(r_dimes) : w_half;
    assign w_need      = SW'(amount) - (w_dimes_use << 1);
    assign w_reject    = w_need > SW'(r_nickels);
`else
    assign w_reject    = 1'b0;
`endif

    // Load and dispense of the same coin in one cycle cancel out
    always_comb begin
        w_nickel_next = r_nickels;
        if (w_give_nickel && !load_nickel)
            w_nickel_next = r_nickels - CNT_W'(1);
        else if (load_nickel && !w_give_nickel && r_nickels != CNT_MAX)
            w_nickel_next = r_nickels + CNT_W'(1);
    end

    always_comb begin
        w_dime_next = r_dimes;
        if (w_give_dime && !load_dime)
            w_dime_next = r_dimes - CNT_W'(1);
        else if (load_dime && !w_give_dime && r_dimes != CNT_MAX)
            w_dime_next = r_dimes + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_nickels   <= CNT_W'(INIT_NICKELS);
            r_dimes     <= CNT_W'(INIT_DIMES);
            r_coin      <= 2'b00;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_nickels <= w_nickel_next;
            r_dimes   <= w_dime_next;
            unique case (r_state)
                S_IDLE: begin
                    r_coin  <= 2'b00;
                    r_done  <= 1'b0;
                    r_short <= 1'b0;
                    if (req) begin
                        r_remaining <= amount;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_short <= 1'b1;
                        end else begin
                            r_state <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (w_give_dime) begin
                        r_coin      <= 2'b10;
                        r_remaining <= r_remaining - AMT_W'(2);
                    end else if (w_give_nickel) begin
                        r_coin      <= 2'b01;
                        r_remaining <= r_remaining - AMT_W'(1);
                    end else begin
                        r_coin  <= 2'b00;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_short <= (r_remaining != '0);
                    end
                end
                S_DONE: begin
                    r_coin  <= 2'b00;
                    r_done  <= 1'b0;
                    r_short <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_coin  <= 2'b00;
                    r_done  <= 1'b0;
                    r_short <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign coin       = r_coin;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign short      = r_short;
    assign nickel_cnt = r_nickels;
    assign dime_cnt   = r_dimes;

endmodule
